// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register.
// Handles load-use stalls, branch redirects and saturating event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      PCOut,
  input  logic [31:0]      InstructionIn,
  input  logic             branchTaken,
  input  logic [31:0]      branchTarget,
  input  logic             EXMemRead,
  input  logic [4:0]       EXRtReg,
  output logic [31:0]      InstructionOut,
  output logic [31:0]      PCAddResultOut,
  output logic             validOut,
  output logic             flushIDEX,
  output logic [CNT_W-1:0] stallCountOut,
  output logic [CNT_W-1:0] flushCountOut
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if_id_t           if_id_q;
  logic [31:0]      pc_q;
  logic [31:0]      pc_plus4;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             rs_hit;
  logic             rt_hit;
  logic             hazard;

  assign pc_plus4 = pc_q + 32'd4;

  assign rs_hit = EXRtReg == if_id_q.instr[25:21];
  assign rt_hit = EXRtReg == if_id_q.instr[20:16];

  // A load in EX whose target is read by the instruction now in ID
  assign hazard = EXMemRead & if_id_q.valid
                & (EXRtReg != 5'd0) & (rs_hit | rt_hit);

  assign flushIDEX = branchTaken | hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      if_id_q   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      priority case (1'b1)
        branchTaken: begin
          pc_q    <= {branchTarget[31:2], 2'b00};
          if_id_q <= '0;
          if (flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + 1'b1;
        end
        hazard: begin
          if (stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
        end
        default: begin
          pc_q          <= pc_plus4;
          if_id_q.instr <= InstructionIn;
          if_id_q.pc4   <= pc_plus4;
          if_id_q.valid <= 1'b1;
        end
      endcase
    end
  end

  assign PCOut          = pc_q;
  assign InstructionOut = if_id_q.instr;
  assign PCAddResultOut = if_id_q.pc4;
  assign validOut       = if_id_q.valid;
  assign stallCountOut  = stall_cnt;
  assign flushCountOut  = flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage.
// Random and directed traffic checked against a rule-level model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCOut;
  logic [31:0] InstructionIn;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        EXMemRead;
  logic [4:0]  EXRtReg;
  logic [31:0] InstructionOut;
  logic [31:0] PCAddResultOut;
  logic        validOut;
  logic        flushIDEX;
  logic [15:0] stallCountOut;
  logic [15:0] flushCountOut;

  if_id_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PCOut          (PCOut),
    .InstructionIn  (InstructionIn),
    .branchTaken    (branchTaken),
    .branchTarget   (branchTarget),
    .EXMemRead      (EXMemRead),
    .EXRtReg        (EXRtReg),
    .InstructionOut (InstructionOut),
    .PCAddResultOut (PCAddResultOut),
    .validOut       (validOut),
    .flushIDEX      (flushIDEX),
    .stallCountOut  (stallCountOut),
    .flushCountOut  (flushCountOut)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  assign InstructionIn = mem[PCOut[7:2]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        flush;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t expq[$];
  int compared   = 0;
  int mismatched = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_stalls, m_flushes;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic bit m_hazard(input bit mr, input logic [4:0] rt);
    return mr && m_valid && rt != 0 &&
           (rt == m_instr[25:21] || rt == m_instr[20:16]);
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic push_exp(input bit br, input bit haz);
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.flush = br | haz;
    e.scnt = sat(m_stalls); e.fcnt = sat(m_flushes);
    expq.push_back(e);
  endtask

  // One cycle: drive, record what should be visible, then predict the edge
  task automatic step(input bit br, input logic [31:0] tgt,
                      input bit mr, input logic [4:0] rt);
    bit haz;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    branchTaken = br; branchTarget = tgt;
    EXMemRead = mr; EXRtReg = rt;
    haz = m_hazard(mr, rt);
    push_exp(br, haz);
    if (br) begin
      m_pc = {tgt[31:2], 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_flushes++;
    end else if (haz) begin
      m_stalls++;
    end else begin
      m_instr = mem[m_pc[7:2]];
      m_pc = m_pc + 32'd4;
      m_pc4 = m_pc;
      m_valid = 1'b1;
    end
  endtask

  // Assert reset between edges; outputs must clear with no clock
  task automatic do_reset(input bit br);
    @(posedge clk);
    #2;
    branchTaken = br;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_pc", PCOut, 32'h0);
    chk("async_instr", InstructionOut, 32'h0);
    chk("async_pc4", PCAddResultOut, 32'h0);
    chk("async_valid", 32'(validOut), 32'h0);
    chk("async_scnt", 32'(stallCountOut), 32'h0);
    chk("async_fcnt", 32'(flushCountOut), 32'h0);
    chk("async_flush", 32'(flushIDEX), 32'(br));
    push_exp(br, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("PCOut", PCOut, e.pc);
        chk("InstructionOut", InstructionOut, e.instr);
        chk("PCAddResultOut", PCAddResultOut, e.pc4);
        chk("validOut", 32'(validOut), 32'(e.valid));
        chk("flushIDEX", 32'(flushIDEX), 32'(e.flush));
        chk("stallCount", 32'(stallCountOut), 32'(e.scnt));
        chk("flushCount", 32'(flushCountOut), 32'(e.fcnt));
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 64; i++)
      mem[i] = {6'h23, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 16'($urandom)};
    mem[0] = 32'h00A6_4820;
    rst_n = 1'b0;
    branchTaken = 0; branchTarget = 0;
    EXMemRead = 0; EXRtReg = 0;
    m_reset();

    // reset then free run
    do_reset(1'b1);
    repeat (5) step(0, 0, 0, 0);

    // load-use on rs=5, then resume
    do_reset(1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 5);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // simultaneous hazard and branch, then redirect
    do_reset(1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 6);
    step(1, 32'h0000_0200, 1, 6);
    step(1, 32'h0000_0103, 0, 0);
    step(0, 0, 0, 0);

    // PC wrap
    step(1, 32'hFFFF_FFFE, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // stall counter saturation, then reset mid-stall
    do_reset(1'b0);
    step(0, 0, 0, 0);
    repeat (65540) step(0, 0, 1, 5);
    do_reset(1'b0);
    step(0, 0, 1, 5);
    step(0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset(1'($urandom_range(0, 1)));
      else
        step($urandom_range(0, 7) == 0, $urandom,
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
    end

    for (int w = 0; w < 5 && expq.size() > 0; w++)
      @(posedge clk);
    chk("drain", 32'(expq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
